// File: rtl/pwm_array.sv
// Multi-channel PWM generator with double-buffered duty bank and tick prescaler.
// A full bank of STAGE duty words is streamed into shadow registers and committed
// to the active compare registers only at a period boundary (or any clk while
// stopped), so a period never mixes old and new duties.
// Optional feature: define PWM_CENTER_EN to add the `center` port and up/down
// (center-aligned) counting; without it the block is edge-aligned only.
module pwm_array #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned STAGE  = 8,
  parameter int unsigned PSC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PSC_W-1:0]  psc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] data,
`ifdef PWM_CENTER_EN
  input  logic              center,
`endif
  output logic [STAGE-1:0]  out,
  output logic              period_start,
  output logic              pending
);

  localparam int unsigned PtrW = (STAGE > 1) ? $clog2(STAGE) : 1;
  localparam logic [DWIDTH-1:0] MaxCnt = '1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(STAGE - 1);

  typedef enum logic {StStop, StRun} state_e;

  state_e              state_q, state_d;
  logic [DWIDTH-1:0]   cnt_q, cnt_d;
  logic [PSC_W-1:0]    pre_q, pre_d;
  logic [PSC_W-1:0]    psc_q, psc_d;
  logic [PtrW-1:0]     wr_ptr_q;
  logic                pending_q;
  logic [DWIDTH-1:0]   shadow_q [STAGE];
  logic [DWIDTH-1:0]   active_q [STAGE];
  logic [DWIDTH-1:0]   active_nx [STAGE];
  logic [STAGE-1:0]    out_q, out_d;
  logic                ps_q, ps_d;
  logic                tick, boundary, accept, commit;
`ifdef PWM_CENTER_EN
  logic                up_q, up_d;
  logic                mode_q, mode_d;
`endif

  assign accept       = in_valid && !pending_q;
  assign commit       = pending_q && ((state_q == StStop) || boundary);
  assign in_ready     = !pending_q;
  assign pending      = pending_q;
  assign out          = out_q;
  assign period_start = ps_q;

  // Run control, prescaler and period counter next-state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    psc_d    = psc_q;
    tick     = 1'b0;
    boundary = 1'b0;
`ifdef PWM_CENTER_EN
    up_d     = up_q;
    mode_d   = mode_q;
`endif
    unique case (state_q)
      StStop: begin
        cnt_d = '0;
        pre_d = '0;
        psc_d = psc;
`ifdef PWM_CENTER_EN
        up_d  = 1'b1;
`endif
        if (start) begin
          // First tick is presented immediately as count 0 with a boundary.
          state_d  = StRun;
          boundary = 1'b1;
`ifdef PWM_CENTER_EN
          mode_d   = center;
`endif
        end
      end
      StRun: begin
        if (!start) begin
          state_d = StStop;
          cnt_d   = '0;
          pre_d   = '0;
`ifdef PWM_CENTER_EN
          up_d    = 1'b1;
`endif
        end else begin
          if (pre_q == psc_q) begin
            tick  = 1'b1;
            pre_d = '0;
            psc_d = psc;
          end else begin
            pre_d = pre_q + 1'b1;
          end
          if (tick) begin
`ifdef PWM_CENTER_EN
            if (mode_q) begin
              if (up_q) begin
                if (cnt_q == MaxCnt) begin
                  up_d  = 1'b0;
                  cnt_d = MaxCnt - 1'b1;
                end else begin
                  cnt_d = cnt_q + 1'b1;
                end
              end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == DWIDTH'(1)) begin
                  up_d     = 1'b1;
                  boundary = 1'b1;
                end
              end
            end else begin
`endif
              cnt_d    = cnt_q + 1'b1;
              boundary = (cnt_q == MaxCnt);
`ifdef PWM_CENTER_EN
            end
            if (boundary) begin
              mode_d = center;
              up_d   = 1'b1;
            end
`endif
          end
        end
      end
      default: state_d = StStop;
    endcase
  end

  // Compare against the duties that will be active after this edge.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < STAGE; i++) begin
      active_nx[i] = commit ? shadow_q[i] : active_q[i];
      out_d[i]     = (state_d == StRun) && (cnt_d < active_nx[i]);
    end
    ps_d = boundary && (state_d == StRun);
  end

  // Counter, run state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StStop;
      cnt_q   <= '0;
      pre_q   <= '0;
      psc_q   <= '0;
      out_q   <= '0;
      ps_q    <= 1'b0;
`ifdef PWM_CENTER_EN
      up_q    <= 1'b1;
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      psc_q   <= psc_d;
      out_q   <= out_d;
      ps_q    <= ps_d;
`ifdef PWM_CENTER_EN
      up_q    <= up_d;
      mode_q  <= mode_d;
`endif
    end
  end

  // Load path into shadow bank and commit to active bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < STAGE; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        shadow_q[wr_ptr_q] <= data;
        if (wr_ptr_q == LastPtr) begin
          wr_ptr_q  <= '0;
          pending_q <= 1'b1;
        end else begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
      end
      if (commit) begin
        pending_q <= 1'b0;
        for (int i = 0; i < STAGE; i++) active_q[i] <= shadow_q[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_array.sv
// Scoreboard bench for pwm_array: stimulus pushes expected per-period results
// (period length and high-clk count per channel); a monitor measures each period
// between period_start pulses and compares against the queue head.
module tb_pwm_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] psc;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic [3:0] pwm_out;
  logic       period_start;
  logic       pending;
`ifdef PWM_CENTER_EN
  logic       c_start, c_center, c_valid, c_ready, c_ps, c_pending;
  logic [3:0] c_psc;
  logic [3:0] c_data;
  logic [1:0] c_out;
`endif

  typedef struct packed {
    logic [15:0]      len;
    logic [3:0][15:0] hi;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   armed  = 1'b0;
  bit   measuring = 1'b0;
  int   cyc;
  int   hi_cnt [4];

  always #5 clk = ~clk;

  pwm_array #(.DWIDTH(8), .STAGE(4), .PSC_W(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .psc          (psc),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data         (data),
`ifdef PWM_CENTER_EN
    .center       (1'b0),
`endif
    .out          (pwm_out),
    .period_start (period_start),
    .pending      (pending)
  );

`ifdef PWM_CENTER_EN
  pwm_array #(.DWIDTH(4), .STAGE(2), .PSC_W(4)) u_ctr (
    .clk          (clk),
    .rst          (rst),
    .start        (c_start),
    .psc          (c_psc),
    .in_valid     (c_valid),
    .in_ready     (c_ready),
    .data         (c_data),
    .center       (c_center),
    .out          (c_out),
    .period_start (c_ps),
    .pending      (c_pending)
  );
`endif

  function automatic void check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  function automatic void expect_period(input int len, input int h0, input int h1,
                                        input int h2, input int h3);
    exp_t e;
    e.len   = 16'(len);
    e.hi[0] = 16'(h0);
    e.hi[1] = 16'(h1);
    e.hi[2] = 16'(h2);
    e.hi[3] = 16'(h3);
    q.push_back(e);
  endfunction

  // Monitor: close a period on each period_start and score it against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!armed) begin
      measuring = 1'b0;
    end else if (period_start) begin
      if (measuring && q.size() > 0) begin
        e = q.pop_front();
        check("period_len", cyc, int'(e.len));
        for (int i = 0; i < 4; i++) check($sformatf("high_clks_ch%0d", i), hi_cnt[i],
                                          int'(e.hi[i]));
      end
      measuring = 1'b1;
      cyc = 0;
      for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    end
    if (measuring) begin
      cyc++;
      for (int i = 0; i < 4; i++) hi_cnt[i] += int'(pwm_out[i]);
    end
  end

  task automatic send(input logic [7:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    data     = w;
    for (int k = 0; k < 2000 && !in_ready; k++) @(negedge clk);
    check("send_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    for (int k = 0; k < budget && q.size() > 0; k++) @(negedge clk);
    check(nm, q.size(), 0);
    q.delete();
  endtask

  task automatic wait_ps(input string nm, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (period_start) break;
    end
    check(nm, int'(k < budget), 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; psc = 8'd0; in_valid = 1'b0; data = 8'd0;
`ifdef PWM_CENTER_EN
    c_start = 1'b0; c_center = 1'b0; c_valid = 1'b0; c_psc = 4'd0; c_data = 4'd0;
`endif
    // Reset held with start high.
    repeat (3) @(negedge clk);
    check("rst_out", int'(pwm_out), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_pending", int'(pending), 0);
    check("rst_period_start", int'(period_start), 0);
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_out", int'(pwm_out), 0);
    check("idle_period_start", int'(period_start), 0);

    // Load 0,64,128,255 while stopped, then run with psc=0.
    send(8'd0); send(8'd64); send(8'd128); send(8'd255);
    @(negedge clk);
    check("full_bank_pending", int'(pending), 1);
    check("full_bank_in_ready", int'(in_ready), 0);
    @(negedge clk);
    check("stop_commit_pending", int'(pending), 0);
    armed = 1'b1;
    expect_period(256, 0, 64, 128, 255);
    expect_period(256, 0, 64, 128, 255);
    start = 1'b1;
    drain("drain_load", 700);

    // Double buffering: new bank mid-period commits only at next boundary.
    expect_period(256, 0, 64, 128, 255);
    expect_period(256, 32, 32, 32, 32);
    repeat (40) @(negedge clk);
    send(8'd32); send(8'd32); send(8'd32); send(8'd32);
    @(negedge clk);
    check("mid_period_pending", int'(pending), 1);
    check("mid_period_in_ready", int'(in_ready), 0);
    wait_ps("wait_boundary", 300);
    check("boundary_pending", int'(pending), 0);
    check("boundary_in_ready", int'(in_ready), 1);
    drain("drain_dbuf", 700);

    // Prescaler: psc=3, duty 10 -> 40 of 1024 clks.
    armed = 1'b0;
    start = 1'b0;
    @(negedge clk);
    psc = 8'd3;
    send(8'd10); send(8'd10); send(8'd10); send(8'd10);
    repeat (2) @(negedge clk);
    check("psc_commit_pending", int'(pending), 0);
    armed = 1'b1;
    expect_period(1024, 40, 40, 40, 40);
    start = 1'b1;
    drain("drain_psc", 2500);

    // Immediate stop at count 100.
    armed = 1'b0;
    start = 1'b0;
    @(negedge clk);
    psc = 8'd0;
    send(8'd200); send(8'd200); send(8'd200); send(8'd200);
    repeat (2) @(negedge clk);
    start = 1'b1;
    wait_ps("wait_run_start", 300);
    repeat (99) @(negedge clk);
    check("count99_out", int'(pwm_out), 15);
    start = 1'b0;
    @(negedge clk);
    check("stop_out", int'(pwm_out), 0);
    check("stop_period_start", int'(period_start), 0);

    // Reset mid-load discards the partial bank.
    send(8'd1); send(8'd2);
    rst = 1'b0;
    @(negedge clk);
    check("midload_rst_out", int'(pwm_out), 0);
    check("midload_rst_pending", int'(pending), 0);
    check("midload_rst_in_ready", int'(in_ready), 1);
    rst = 1'b1;
    send(8'd20); send(8'd40); send(8'd60); send(8'd80);
    repeat (2) @(negedge clk);
    check("reload_pending", int'(pending), 0);
    armed = 1'b1;
    expect_period(256, 20, 40, 60, 80);
    start = 1'b1;
    drain("drain_reload", 700);
    armed = 1'b0;
    start = 1'b0;

`ifdef PWM_CENTER_EN
    // Center mode, DWIDTH=4, duty 3: period 30, 5 contiguous high clks.
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      c_valid = 1'b1;
      c_data  = 4'd3;
      @(posedge clk);
      #1;
      c_valid = 1'b0;
    end
    repeat (2) @(negedge clk);
    c_center = 1'b1;
    c_start  = 1'b1;
    begin
      int k;
      int hc;
      for (k = 0; k < 100; k++) begin
        @(negedge clk);
        if (c_ps) break;
      end
      check("ctr_first_ps", int'(k < 100), 1);
      hc = 0;
      for (int j = 0; j < 30; j++) begin
        if (j > 0) @(negedge clk);
        hc += int'(c_out[0]);
        if (j == 2) check("ctr_up2_high", int'(c_out[0]), 1);
        if (j == 3) check("ctr_up3_low", int'(c_out[0]), 0);
        if (j == 27) check("ctr_down3_low", int'(c_out[0]), 0);
        if (j == 28) check("ctr_down2_high", int'(c_out[0]), 1);
      end
      check("ctr_high_clks", hc, 5);
      @(negedge clk);
      check("ctr_period_30", int'(c_ps), 1);
    end
    c_start = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
